irq_pending_latch_4: RTL and testbench

Four-channel interrupt front end sitting directly upstream of the 4-to-2 priority encoder. Synchronises four asynchronous request lines, detects rising edges, and holds each event in a pending register until the consumer acknowledges it by channel index. The masked pending vector drives the encoder's `in[3:0]`. The encoder's `out[1:0]` comes back to this block as `ack_id` once the consumer services the winning channel.

---
 rtl/irq_pending_latch_4.sv | 109 ++++++++++
 tb/tb_irq_pending_latch_4.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch_4.sv
// irq_pending_latch_4
//   Four-channel interrupt front end feeding a 4-to-2 priority encoder.
//   Each raw request line is synchronised and rise-detected. Every rising
//   edge sets a per-channel pending bit, which stays set until the consumer
//   acknowledges that channel by index. A rise that lands on a channel that
//   is already pending (and is not acked in the same cycle) sets a sticky
//   overrun flag.
//
// Ports
//   clk       single clock, rising edge
//   rst_n     async active-low reset
//   req_in    [3:0] raw asynchronous request lines
//   mask      [3:0] 1 = channel hidden from pend_out/irq (latching continues)
//   ack       one-cycle acknowledge pulse
//   ack_id    [1:0] channel being acknowledged (used only while ack=1)
//   pend_out  [3:0] registered pending & ~mask -> encoder in[3:0]
//   irq       registered OR of pend_out
//   ovr       [3:0] sticky per-channel overrun
//
// Parameter
//   SYNC_STAGES  synchroniser depth, 2..4

// Per-channel synchroniser, edge detect, pending and overrun state.
module irq_pend_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack_hit,
  output logic pnd,
  output logic ovr
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pnd    <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (rise) begin
        // New event always wins over a same-cycle ack; the ack still
        // retires the old event, so it clears any overrun.
        pnd <= 1'b1;
        if (ack_hit)  ovr <= 1'b0;
        else if (pnd) ovr <= 1'b1;
      end else if (ack_hit && pnd) begin
        pnd <= 1'b0;
        ovr <= 1'b0;
      end
    end
  end

endmodule

module irq_pending_latch_4 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  input  logic       ack,
  input  logic [1:0] ack_id,
  output logic [3:0] pend_out,
  output logic       irq,
  output logic [3:0] ovr
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] pnd;
  logic [NUM_LANES-1:0] vis;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    irq_pend_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_in[i]),
      .ack_hit (ack && (ack_id == 2'(i))),
      .pnd     (pnd[i]),
      .ovr     (ovr[i])
    );
  end

  assign vis = pnd & ~mask;

  // pend_out and irq come from the same register stage so the encoder
  // never sees irq without a matching pending bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_out <= '0;
      irq      <= 1'b0;
    end else begin
      pend_out <= vis;
      irq      <= |vis;
    end
  end

endmodule

// File: tb/tb_irq_pending_latch_4.sv
module tb_irq_pending_latch_4;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic       ack;
  logic [1:0] ack_id;
  logic [3:0] pend_out;
  logic       irq;
  logic [3:0] ovr;

  int n_chk  = 0;
  int n_fail = 0;

  irq_pending_latch_4 #(.SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .mask     (mask),
    .ack      (ack),
    .ack_id   (ack_id),
    .pend_out (pend_out),
    .irq      (irq),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic ack_ch(input logic [1:0] id);
    ack = 1'b1; ack_id = id;
    step();
    ack = 1'b0; ack_id = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0; req_in = '0; mask = '0; ack = 1'b0; ack_id = '0;

    // ---- reset / idle
    step(3);
    chk("rst_pend", pend_out, 4'b0000);
    chk("rst_irq",  {3'b0, irq}, 4'b0000);
    chk("rst_ovr",  ovr, 4'b0000);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_pend", pend_out, 4'b0000);
      chk("idle_irq",  {3'b0, irq}, 4'b0000);
      chk("idle_ovr",  ovr, 4'b0000);
    end

    // ---- single event on channel 2, latency then ack
    req_in[2] = 1'b1;             // before edge 0
    step(3);                      // after edge 2: pnd set, pend_out not yet
    chk("lat_early_pend", pend_out, 4'b0000);
    chk("lat_early_irq",  {3'b0, irq}, 4'b0000);
    step();                       // after edge 3
    chk("lat_pend", pend_out, 4'b0100);
    chk("lat_irq",  {3'b0, irq}, 4'b0001);
    step(2);
    chk("held_level_pend", pend_out, 4'b0100);
    chk("held_level_ovr",  ovr, 4'b0000);
    ack_ch(2'd2);                 // ack edge k
    chk("ack_k_pend", pend_out, 4'b0100);
    step();                       // edge k+1
    chk("ack_k1_pend", pend_out, 4'b0000);
    chk("ack_k1_irq",  {3'b0, irq}, 4'b0000);
    req_in[2] = 1'b0;
    step(4);
    chk("after_fall_pend", pend_out, 4'b0000);

    // ---- overrun on channel 1
    req_in[1] = 1'b1; step(4);
    req_in[1] = 1'b0; step(4);
    chk("ovr_first_pend", pend_out, 4'b0010);
    chk("ovr_first_ovr",  ovr, 4'b0000);
    req_in[1] = 1'b1; step(4);
    req_in[1] = 1'b0; step(4);
    chk("ovr_pend", pend_out, 4'b0010);
    chk("ovr_ovr",  ovr, 4'b0010);
    ack_ch(2'd0);                 // channel 0 not pending: ignored
    step();
    chk("ack_idle_ch_pend", pend_out, 4'b0010);
    chk("ack_idle_ch_ovr",  ovr, 4'b0010);
    ack_ch(2'd1);
    chk("ovr_ack_ovr", ovr, 4'b0000);
    step();
    chk("ovr_ack_pend", pend_out, 4'b0000);
    chk("ovr_ack_irq",  {3'b0, irq}, 4'b0000);

    // ---- simultaneous rise + ack on channel 3 (with overrun already set)
    req_in[3] = 1'b1; step(4);
    req_in[3] = 1'b0; step(4);
    req_in[3] = 1'b1; step(4);
    req_in[3] = 1'b0; step(4);
    chk("sim_pre_ovr",  ovr, 4'b1000);
    chk("sim_pre_pend", pend_out, 4'b1000);
    req_in[3] = 1'b1;             // before edge k
    step(2);                      // rise visible to pnd logic at edge k+2
    ack_ch(2'd3);                 // edge k+2: rise and ack together
    chk("sim_ovr", ovr, 4'b0000);
    step();
    chk("sim_pend", pend_out, 4'b1000);
    chk("sim_irq",  {3'b0, irq}, 4'b0001);
    ack_ch(2'd3);
    step();
    chk("sim_clear_pend", pend_out, 4'b0000);
    req_in[3] = 1'b0;
    step(4);

    // ---- mask on channel 0
    mask = 4'b0001;
    req_in[0] = 1'b1;
    step(6);
    chk("mask_pend", pend_out, 4'b0000);
    chk("mask_irq",  {3'b0, irq}, 4'b0000);
    mask = 4'b0000;
    step();
    chk("unmask_pend", pend_out, 4'b0001);
    chk("unmask_irq",  {3'b0, irq}, 4'b0001);
    mask = 4'b0001;
    ack_ch(2'd0);                 // ack while masked still clears
    mask = 4'b0000;
    step(2);
    chk("mask_ack_pend", pend_out, 4'b0000);
    chk("mask_ack_irq",  {3'b0, irq}, 4'b0000);
    req_in[0] = 1'b0;
    step(4);

    // ---- mid-run reset with pending 1010, req[3] held high
    req_in = 4'b1010;
    step(4);
    chk("pre_rst_pend", pend_out, 4'b1010);
    req_in = 4'b1000;
    step(4);
    req_in = 4'b1010;             // second rise on ch1 -> overrun
    step(4);
    req_in = 4'b1000;
    step(1);
    chk("pre_rst_ovr", ovr, 4'b0010);
    #2 rst_n = 1'b0;              // mid-cycle, away from any edge
    #1;
    chk("async_rst_pend", pend_out, 4'b0000);
    chk("async_rst_irq",  {3'b0, irq}, 4'b0000);
    chk("async_rst_ovr",  ovr, 4'b0000);
    step();
    rst_n = 1'b1;                 // released before edge 0
    step(3);
    chk("post_rst_early", pend_out, 4'b0000);
    step();
    chk("post_rst_pend", pend_out, 4'b1000);
    chk("post_rst_irq",  {3'b0, irq}, 4'b0001);
    chk("post_rst_ovr",  ovr, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
